// File: rtl/calc_pkg.sv
// Shared keypad types: raw button levels, decoded button codes, debouncer states and
// the priority encoder that turns a raw level vector into a single code.
package calc_pkg;

    typedef struct packed {
        logic mem_rcl;
        logic mem_sub;
        logic mem_add;
        logic op_neg;
        logic op_pct;
        logic op_eq;
        logic op_div;
        logic op_mul;
        logic op_sub;
        logic op_add;
        logic dot;
        logic num_9;
        logic num_8;
        logic num_7;
        logic num_6;
        logic num_5;
        logic num_4;
        logic num_3;
        logic num_2;
        logic num_1;
        logic num_0;
        logic off;
        logic on;
    } buttons_t;

    // A single pressed bit at position i decodes to code i+1.
    typedef enum logic [4:0] {
        B_NONE    = 5'd0,
        B_ON      = 5'd1,
        B_OFF     = 5'd2,
        B_NUM_0   = 5'd3,
        B_NUM_1   = 5'd4,
        B_NUM_2   = 5'd5,
        B_NUM_3   = 5'd6,
        B_NUM_4   = 5'd7,
        B_NUM_5   = 5'd8,
        B_NUM_6   = 5'd9,
        B_NUM_7   = 5'd10,
        B_NUM_8   = 5'd11,
        B_NUM_9   = 5'd12,
        B_DOT     = 5'd13,
        B_OP_ADD  = 5'd14,
        B_OP_SUB  = 5'd15,
        B_OP_MUL  = 5'd16,
        B_OP_DIV  = 5'd17,
        B_OP_EQ   = 5'd18,
        B_OP_PCT  = 5'd19,
        B_OP_NEG  = 5'd20,
        B_MEM_ADD = 5'd21,
        B_MEM_SUB = 5'd22,
        B_MEM_RCL = 5'd23,
        B_UNKNOWN = 5'd31
    } active_button_t;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} debounce_state_t;

    // Power wins over everything; otherwise chords decode as B_UNKNOWN.
    function automatic active_button_t encode_buttons(input buttons_t b);
        logic [22:0]    w_bits;
        active_button_t w_code;
        w_bits = b;
        w_code = B_NONE;
        if (b.on) begin
            w_code = B_ON;
        end else if ($countones(w_bits) > 1) begin
            w_code = B_UNKNOWN;
        end else begin
            for (int i = 0; i < 23; i++) begin
                if (w_bits[i]) w_code = active_button_t'(5'(i + 1));
            end
        end
        return w_code;
    endfunction

    function automatic logic is_repeatable(input active_button_t b);
        return ((b >= B_NUM_0) && (b <= B_DOT)) ||
               ((b >= B_MEM_ADD) && (b <= B_MEM_RCL));
    endfunction

endpackage

// File: rtl/calc_button_decoder_if.sv
// Event output channel of the keypad decoder: payload, valid/ready handshake and drop pulse.
interface calc_button_decoder_if;
    import calc_pkg::*;

    active_button_t button_o;
    logic           button_valid_o;
    logic           button_ready_i;
    logic           dropped_o;

    modport master (output button_o, output button_valid_o, output dropped_o,
                    input  button_ready_i);
    modport slave  (input  button_o, input  button_valid_o, input  dropped_o,
                    output button_ready_i);
endinterface

// File: rtl/calc_sync.sv
// Per-bit two-flop synchronizer for levels arriving asynchronously to clk_i.
module calc_sync #(
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    genvar gi;
    generate
        for (gi = 0; gi < Width; gi++) begin : g_bit
            logic r_meta;
            logic r_sync;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= d_i[gi];
                    r_sync <= r_meta;
                end
            end
            assign q_o[gi] = r_sync;
        end
    endgenerate
endmodule

// File: rtl/calc_button_decoder.sv
// Debounces raw keypad levels into single-press events on a one-entry valid/ready slot.
// Define CALC_AUTOREPEAT_EN to re-emit held number/dot/memory keys at a repeat rate.
module calc_button_decoder
    import calc_pkg::*;
#(
    parameter int DebounceCycles     = 1000,
    parameter int RepeatDelayCycles  = 50000,
    parameter int RepeatPeriodCycles = 10000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  buttons_t              buttons_i,
    calc_button_decoder_if.master out_if
);
    localparam int MaxA      = (DebounceCycles > RepeatDelayCycles) ? DebounceCycles : RepeatDelayCycles;
    localparam int MaxCycles = (MaxA > RepeatPeriodCycles) ? MaxA : RepeatPeriodCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
`ifdef CALC_AUTOREPEAT_EN
    localparam logic [CntW-1:0] DelLast = CntW'(RepeatDelayCycles - 1);
    localparam logic [CntW-1:0] PerLast = CntW'(RepeatPeriodCycles - 1);
`endif

    logic [$bits(buttons_t)-1:0] w_sync_bits;
    active_button_t              w_sample;
    debounce_state_t             r_state, w_state_next;
    active_button_t              r_cand, w_cand_next;
    logic [CntW-1:0]             r_cnt, w_cnt_next, w_cnt_inc;
    logic                        w_emit;
    active_button_t              r_slot_button;
    logic                        r_slot_valid;
    logic                        r_dropped;
    logic                        w_handshake;
`ifdef CALC_AUTOREPEAT_EN
    logic                        r_rep_phase, w_rep_phase_next;
`endif

    calc_sync #(.Width($bits(buttons_t))) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (buttons_i),
        .q_o   (w_sync_bits)
    );

    assign w_sample  = encode_buttons(buttons_t'(w_sync_bits));
    assign w_cnt_inc = (r_cnt == {CntW{1'b1}}) ? r_cnt : r_cnt + CntW'(1);

    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        w_emit       = 1'b0;
`ifdef CALC_AUTOREPEAT_EN
        w_rep_phase_next = r_rep_phase;
`endif
        case (r_state)
            IDLE: begin
                if (w_sample != B_NONE) begin
                    w_cand_next  = w_sample;
                    w_cnt_next   = '0;
                    w_state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (w_sample != r_cand) begin
                    if (w_sample == B_NONE) begin
                        w_state_next = IDLE;
                    end else begin
                        w_cand_next = w_sample;
                        w_cnt_next  = '0;
                    end
                end else if (r_cnt == DebLast) begin
                    // A chord still parks in HELD so it must be released before the next press.
                    w_state_next = HELD;
                    w_cnt_next   = '0;
                    w_emit       = (r_cand != B_UNKNOWN);
`ifdef CALC_AUTOREPEAT_EN
                    w_rep_phase_next = 1'b0;
`endif
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            HELD: begin
                if (w_sample != r_cand) begin
                    w_cnt_next   = '0;
                    w_state_next = RELEASE;
                end
`ifdef CALC_AUTOREPEAT_EN
                else if (is_repeatable(r_cand)) begin
                    if (r_cnt == (r_rep_phase ? PerLast : DelLast)) begin
                        w_emit           = 1'b1;
                        w_cnt_next       = '0;
                        w_rep_phase_next = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
`endif
            end
            RELEASE: begin
                if (w_sample == B_NONE) begin
                    if (r_cnt == DebLast) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_handshake = r_slot_valid & out_if.button_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_cand        <= B_NONE;
            r_cnt         <= '0;
            r_slot_button <= B_NONE;
            r_slot_valid  <= 1'b0;
            r_dropped     <= 1'b0;
`ifdef CALC_AUTOREPEAT_EN
            r_rep_phase   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
`ifdef CALC_AUTOREPEAT_EN
            r_rep_phase <= w_rep_phase_next;
`endif
            // The slot can take a new event in the same cycle the old one is consumed.
            if (w_emit && (!r_slot_valid || w_handshake)) begin
                r_slot_button <= r_cand;
                r_slot_valid  <= 1'b1;
            end else if (w_handshake) begin
                r_slot_valid <= 1'b0;
            end
            r_dropped <= w_emit & r_slot_valid & ~w_handshake;
        end
    end

    assign out_if.button_o       = r_slot_button;
    assign out_if.button_valid_o = r_slot_valid;
    assign out_if.dropped_o      = r_dropped;

endmodule

// File: tb/tb_calc_button_decoder.sv
// Randomised and directed bench for calc_button_decoder against a sample-history model.
module tb_calc_button_decoder;
    import calc_pkg::*;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;
`ifdef CALC_AUTOREPEAT_EN
    localparam int T1Events = 4;
`else
    localparam int T1Events = 1;
`endif

    logic     clk   = 1'b0;
    logic     rst_n = 1'b0;
    logic     ready = 1'b1;
    buttons_t pins  = '0;

    calc_button_decoder_if bus();
    assign bus.button_ready_i = ready;

    calc_button_decoder #(
        .DebounceCycles    (D),
        .RepeatDelayCycles (RD),
        .RepeatPeriodCycles(RP)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .buttons_i(pins),
        .out_if   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: sample history since reset plus arm/hold bookkeeping.
    active_button_t hist [64];
    logic [22:0]    pin_q[$];
    int             te = 0;
    bit             armed = 1'b1;
    bit             left_hold = 1'b0;
    int             t_emit = 0;
    int             t_leave = 0;
    active_button_t hold = B_NONE;
    bit             m_valid = 1'b0;
    bit             m_dropped = 1'b0;
    active_button_t m_button = B_NONE;
    int             n_emit = 0;
    int             n_drop = 0;
    int             emit_log[$];
    active_button_t ev_log[$];
    int             n_hs_dut = 0;
    int             n_drop_dut = 0;
    active_button_t last_hs_button = B_NONE;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic active_button_t tb_enc(input logic [22:0] p);
        int n;
        int idx;
        n   = $countones(p);
        idx = 0;
        if (p[0]) return B_ON;
        if (n == 0) return B_NONE;
        if (n > 1) return B_UNKNOWN;
        while (p[idx] == 1'b0) idx++;
        return active_button_t'(5'(idx + 1));
    endfunction

    function automatic bit tb_repeats(input active_button_t b);
        return (b inside {B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4, B_NUM_5, B_NUM_6,
                          B_NUM_7, B_NUM_8, B_NUM_9, B_DOT, B_MEM_ADD, B_MEM_SUB, B_MEM_RCL});
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) hist[k] = B_NONE;
        pin_q     = {23'd0, 23'd0};
        te        = 0;
        armed     = 1'b1;
        left_hold = 1'b0;
        m_valid   = 1'b0;
        m_dropped = 1'b0;
        m_button  = B_NONE;
    endtask

    // Predicts the outputs after the coming rising edge.
    task automatic model_step(input logic [22:0] p, input logic rdy);
        active_button_t s;
        active_button_t ev;
        bit emit;
        bit ok;
        bit hs;
        s = tb_enc(pin_q[$-1]);
        pin_q.push_back(p);
        if (pin_q.size() > 3) void'(pin_q.pop_front());
        te++;
        hist[te % 64] = s;
        emit = 1'b0;
        ev   = B_NONE;
        if (armed) begin
            // A press is accepted once D+1 consecutive identical samples are seen.
            if (s != B_NONE && te >= D) begin
                ok = 1'b1;
                for (int k = te - D; k < te; k++) if (hist[k % 64] != s) ok = 1'b0;
                if (ok) begin
                    armed     = 1'b0;
                    left_hold = 1'b0;
                    hold      = s;
                    t_emit    = te;
                    if (s != B_UNKNOWN) begin
                        emit = 1'b1;
                        ev   = s;
                    end
                end
            end
        end else if (!left_hold) begin
            if (s != hold) begin
                left_hold = 1'b1;
                t_leave   = te;
            end
`ifdef CALC_AUTOREPEAT_EN
            else if (tb_repeats(hold) && (te - t_emit) >= RD && ((te - t_emit - RD) % RP) == 0) begin
                emit = 1'b1;
                ev   = hold;
            end
`endif
        end else if (te - D >= t_leave) begin
            ok = 1'b1;
            for (int k = te - D + 1; k <= te; k++) if (hist[k % 64] != B_NONE) ok = 1'b0;
            if (ok) armed = 1'b1;
        end
        hs        = m_valid && rdy;
        m_dropped = emit && m_valid && !hs;
        if (emit && (!m_valid || hs)) begin
            m_valid  = 1'b1;
            m_button = ev;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        if (emit) begin
            n_emit++;
            emit_log.push_back(cyc);
            ev_log.push_back(ev);
        end
        if (m_dropped) n_drop++;
    endtask

    always @(negedge clk) begin : compare
        active_button_t v;
        if (!rst_n) model_reset();
        chk("valid", bus.button_valid_o, m_valid);
        if (m_valid || !rst_n) chk("button", bus.button_o, m_button);
        chk("dropped", bus.dropped_o, m_dropped);
        if (bus.dropped_o === 1'b1) n_drop_dut++;
        if (bus.button_valid_o === 1'b1 && ready) begin
            n_hs_dut++;
            v = bus.button_o;
            last_hs_button = v;
            $display("event %s accepted at cycle %0d", v.name(), cyc);
        end
        cyc++;
        if (rst_n) model_step(pins, ready);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        emit_log.delete();
        ev_log.delete();
    endtask

    int pe, base, hs0, dr0, rel;
    logic [22:0] rbits;

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Clean single press.
        clear_logs(); base = n_emit; hs0 = n_hs_dut;
        pins = '0; pins.num_7 = 1'b1; pe = cyc + 1;
        tick(20); pins = '0; tick(15);
        chk("t1_events", n_emit - base, T1Events);
        chk("t1_latency", (emit_log.size() > 0) ? emit_log[0] - pe : -1, 6);
        chk("t1_dut_handshakes", n_hs_dut - hs0, T1Events);
        chk("t1_dut_value", last_hs_button, B_NUM_7);

        // Bouncing key then steady.
        clear_logs(); base = n_emit;
        for (int i = 0; i < 3; i++) begin
            pins.num_3 = 1'b1; tick(2);
            pins.num_3 = 1'b0; tick(2);
        end
        chk("t2_bounce_events", n_emit - base, 0);
        pins.num_3 = 1'b1; pe = cyc + 1;
        tick(12); pins = '0; tick(12);
        chk("t2_events", n_emit - base, 1);
        chk("t2_latency", (emit_log.size() > 0) ? emit_log[0] - pe : -1, 6);

        // Chord is silent; power has priority.
        clear_logs(); base = n_emit; hs0 = n_hs_dut;
        pins.num_1 = 1'b1; pins.num_2 = 1'b1; tick(12); pins = '0; tick(10);
        chk("t3_chord_events", n_emit - base, 0);
        pins.on = 1'b1; pins.num_5 = 1'b1; tick(12); pins = '0; tick(10);
        chk("t3_events", n_emit - base, 1);
        chk("t3_value", (ev_log.size() > 0) ? ev_log[0] : B_NONE, B_ON);
        chk("t3_dut_handshakes", n_hs_dut - hs0, 1);
        chk("t3_dut_value", last_hs_button, B_ON);

        // Back-pressure: second press is dropped.
        clear_logs(); base = n_drop; dr0 = n_drop_dut; hs0 = n_hs_dut;
        ready = 1'b0;
        pins.num_4 = 1'b1; tick(8); pins = '0; tick(8);
        pins.num_6 = 1'b1; tick(8); pins = '0; tick(8);
        chk("t4_model_drops", n_drop - base, 1);
        chk("t4_dut_drops", n_drop_dut - dr0, 1);
        chk("t4_held_button", bus.button_o, B_NUM_4);
        chk("t4_held_valid", bus.button_valid_o, 1);
        ready = 1'b1; tick(4);
        chk("t4_handshakes", n_hs_dut - hs0, 1);
        chk("t4_valid_after", bus.button_valid_o, 0);

        // Reset in the middle of a debounce.
        clear_logs(); base = n_emit;
        pins.num_9 = 1'b1; tick(5);
        chk("t5_pre_reset_events", n_emit - base, 0);
        rst_n = 1'b0; #1;
        chk("t5_reset_valid", bus.button_valid_o, 0);
        chk("t5_reset_button", bus.button_o, B_NONE);
        tick(1); rst_n = 1'b1; rel = cyc + 1;
        tick(12);
        chk("t5_events", n_emit - base, 1);
        chk("t5_latency", (emit_log.size() > 0) ? emit_log[0] - rel : -1, 6);
        pins = '0; tick(12);

`ifdef CALC_AUTOREPEAT_EN
        clear_logs(); base = n_emit;
        pins.num_8 = 1'b1; pe = cyc + 1; tick(20); pins = '0; tick(15);
        chk("t6_events", n_emit - base, 4);
        chk("t6_rep0", (emit_log.size() > 0) ? emit_log[0] - pe : -1, 6);
        chk("t6_rep1", (emit_log.size() > 1) ? emit_log[1] - pe : -1, 14);
        chk("t6_rep2", (emit_log.size() > 2) ? emit_log[2] - pe : -1, 17);
        chk("t6_rep3", (emit_log.size() > 3) ? emit_log[3] - pe : -1, 20);
        clear_logs(); base = n_emit;
        pins.op_add = 1'b1; tick(20); pins = '0; tick(15);
        chk("t6_op_events", n_emit - base, 1);
`endif

        // Random traffic.
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: pins = '0;
                3, 4, 5, 6: begin
                    rbits = 23'd1;
                    rbits = rbits << $urandom_range(0, 22);
                    pins  = buttons_t'(rbits);
                end
                7: begin
                    rbits = 23'd1;
                    rbits = (rbits << $urandom_range(1, 22)) | (rbits << $urandom_range(1, 22));
                    pins  = buttons_t'(rbits);
                end
                8: begin
                    rbits = 23'd1;
                    rbits = (rbits << $urandom_range(1, 22)) | 23'd1;
                    pins  = buttons_t'(rbits);
                end
                default: ;
            endcase
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0; tick(1); rst_n = 1'b1;
            end
            tick($urandom_range(1, 12));
        end
        pins = '0; ready = 1'b1; tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
